// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: memory/IO controller state encoding and IO map.
package slc3_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_IO     = 3'd4
  } mem_io_state_t;

  // Wait-state counter width.
  localparam int unsigned CNT_W = 4;

  // Default IO window: LED register at the base, switches at all-ones.
  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFFE;
  localparam logic [15:0] LED_ADDR        = 16'hFFFE;
  localparam logic [15:0] SW_ADDR         = 16'hFFFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports: clk_i, rst_i (sync, active high), d_i async input, q_o synchronised output.
module sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// SLC-3 memory/IO controller: req/ack handshake to async SRAM with configurable
// wait states, plus a memory-mapped IO window (LED register, hex digits, switches).
// Ports: Clk/Reset; CPU side req, we, addr, wdata, rdata, ack, busy;
// board IO Switches, HEX, LED; SRAM strobes Mem_*, SRAM_ADDR, SRAM_DQ_out/oe/in.
module mem_io_ctrl
  import slc3_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SRAM_ADDR_W = 20,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned NUM_HEX     = 4,
  parameter int unsigned LED_W       = 12,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ack,
  output logic                   busy,
  input  logic [DATA_W-1:0]      Switches,
  output logic [NUM_HEX*4-1:0]   HEX,
  output logic [LED_W-1:0]       LED,
  output logic                   Mem_CE,
  output logic                   Mem_UB,
  output logic                   Mem_LB,
  output logic                   Mem_OE,
  output logic                   Mem_WE,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0]      SRAM_DQ_out,
  output logic                   SRAM_DQ_oe,
  input  logic [DATA_W-1:0]      SRAM_DQ_in
);

  localparam int unsigned HEX_W = NUM_HEX * 4;
  localparam logic [ADDR_W-1:0] SW_ADDR_L = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);

  mem_io_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic dq_oe_q, dq_oe_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic [DATA_W-1:0]      rdata_q;
  logic [HEX_W-1:0]       hex_q;
  logic [LED_W-1:0]       led_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      sw_sync;
  logic                   io_sel;
  logic                   accept;
  logic [DATA_W-1:0]      io_rdata;

  sync2 #(.W(DATA_W)) u_sw_sync (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (Switches),
    .q_o   (sw_sync)
  );

  assign io_sel = (addr >= IO_BASE);
  assign accept = (state_q == ST_IDLE) && req;

  // IO read mux, evaluated on the accepting edge so data is ready with ack.
  always_comb begin
    io_rdata = '0;
    if (addr == IO_BASE) begin
      io_rdata = DATA_W'(led_q);
    end else if (addr == SW_ADDR_L) begin
      io_rdata = sw_sync;
    end
  end

  // Next state, then registered strobe targets decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ack_d   = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          state_d = io_sel ? ST_IO : ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_IO:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_SETUP: begin
        ce_n_d  = 1'b0;
        oe_n_d  = we_d;
        dq_oe_d = we_d;
      end
      ST_ACCESS: begin
        ce_n_d  = 1'b0;
        oe_n_d  = we_d;
        we_n_d  = ~we_d;
        dq_oe_d = we_d;
      end
      ST_DONE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = we_d;
        ack_d   = 1'b1;
      end
      ST_IO:   ack_d = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs; reset aborts any access without an ack.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Datapath: request latching, IO register file and SRAM read capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q     <= '0;
      hex_q       <= '0;
      led_q       <= '0;
      sram_addr_q <= '0;
      wdata_q     <= '0;
    end else begin
      if (accept) begin
        if (io_sel) begin
          if (we) begin
            if (addr == IO_BASE) begin
              led_q <= wdata[LED_W-1:0];
            end else if (addr == SW_ADDR_L) begin
              hex_q <= wdata[HEX_W-1:0];
            end
          end else begin
            rdata_q <= io_rdata;
          end
        end else begin
          sram_addr_q <= SRAM_ADDR_W'(addr);
          wdata_q     <= wdata;
        end
      end
      if ((state_q == ST_ACCESS) && (cnt_q == '0) && !we_q) begin
        rdata_q <= SRAM_DQ_in;
      end
    end
  end

  assign rdata       = rdata_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign HEX         = hex_q;
  assign LED         = led_q;
  assign Mem_CE      = ce_n_q;
  assign Mem_UB      = ce_n_q;
  assign Mem_LB      = ce_n_q;
  assign Mem_OE      = oe_n_q;
  assign Mem_WE      = we_n_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_out = wdata_q;
  assign SRAM_DQ_oe  = dq_oe_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: SRAM read/write timing, IO window, reset abort,
// back-to-back handshake, and a single-wait-state build.
module tb_mem_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Switches;
  logic [15:0] SRAM_DQ_in;

  logic        req, we;
  logic [15:0] addr, wdata, rdata;
  logic        ack, busy;
  logic [15:0] HEX;
  logic [11:0] LED;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;

  logic        req1, we1;
  logic [15:0] addr1, wdata1, rdata1;
  logic        ack1, busy1;
  logic [15:0] HEX1;
  logic [11:0] LED1;
  logic        Mem_CE1, Mem_UB1, Mem_LB1, Mem_OE1, Mem_WE1;
  logic [19:0] SRAM_ADDR1;
  logic [15:0] SRAM_DQ_out1;
  logic        SRAM_DQ_oe1;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mem_io_ctrl #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .Switches(Switches), .HEX(HEX), .LED(LED),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in)
  );

  mem_io_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .Switches(Switches), .HEX(HEX1), .LED(LED1),
    .Mem_CE(Mem_CE1), .Mem_UB(Mem_UB1), .Mem_LB(Mem_LB1), .Mem_OE(Mem_OE1), .Mem_WE(Mem_WE1),
    .SRAM_ADDR(SRAM_ADDR1), .SRAM_DQ_out(SRAM_DQ_out1), .SRAM_DQ_oe(SRAM_DQ_oe1),
    .SRAM_DQ_in(SRAM_DQ_in)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one access on the main DUT and collect strobe statistics up to ack.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output int oe_n, output int we_n,
                           output int dqoe_n, output int ce_n,
                           output logic [19:0] sa, output logic [15:0] dqo);
    lat = -1; oe_n = 0; we_n = 0; dqoe_n = 0; ce_n = 0; sa = '0; dqo = '0;
    we = w; addr = a; wdata = d; req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) begin
        req = 1'b0; sa = SRAM_ADDR; dqo = SRAM_DQ_out;
      end
      if (!Mem_OE) oe_n++;
      if (!Mem_WE) we_n++;
      if (SRAM_DQ_oe) dqoe_n++;
      if (!Mem_CE) ce_n++;
      if (ack) begin
        lat = i;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    n_vec++; if ({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} !== 5'b11111) begin n_err++; $display("FAIL rst_strobes got %b exp 11111", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}); end
    n_vec++; if (SRAM_DQ_oe !== 1'b0) begin n_err++; $display("FAIL rst_dq_oe got %b exp 0", SRAM_DQ_oe); end
    n_vec++; if ({HEX, LED, rdata} !== 44'h0) begin n_err++; $display("FAIL rst_regs got %h/%h/%h exp 0", HEX, LED, rdata); end
    n_vec++; if ({busy, ack} !== 2'b00) begin n_err++; $display("FAIL rst_busy_ack got %b exp 00", {busy, ack}); end
    n_vec++; if (SRAM_ADDR !== 20'h0) begin n_err++; $display("FAIL rst_sram_addr got %h exp 0", SRAM_ADDR); end
    Reset = 1'b0;
    step();
    n_vec++; if ({busy, Mem_CE} !== 2'b01) begin n_err++; $display("FAIL idle got busy/ce %b exp 01", {busy, Mem_CE}); end
  endtask

  task automatic test_sram_read();
    int lat, oe_n, we_n, dqoe_n, ce_n;
    logic [19:0] sa;
    logic [15:0] dqo;
    SRAM_DQ_in = 16'h1234;
    do_access(1'b0, 16'h0010, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rd_latency got %0d exp 4", lat); end
    n_vec++; if (oe_n !== 3) begin n_err++; $display("FAIL rd_oe_cycles got %0d exp 3", oe_n); end
    n_vec++; if (ce_n !== 4) begin n_err++; $display("FAIL rd_ce_cycles got %0d exp 4", ce_n); end
    n_vec++; if ((we_n !== 0) || (dqoe_n !== 0)) begin n_err++; $display("FAIL rd_no_drive got we %0d oe %0d exp 0 0", we_n, dqoe_n); end
    n_vec++; if (sa !== 20'h00010) begin n_err++; $display("FAIL rd_sram_addr got %h exp 00010", sa); end
    n_vec++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL rd_data got %h exp 1234", rdata); end
    n_vec++; if ({busy, Mem_OE, Mem_CE} !== 3'b011) begin n_err++; $display("FAIL rd_after got %b exp 011", {busy, Mem_OE, Mem_CE}); end
    // Highest address below the IO window still goes to SRAM.
    SRAM_DQ_in = 16'hCAFE;
    do_access(1'b0, 16'hFFFD, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL rd_fffd_latency got %0d exp 4", lat); end
    n_vec++; if (sa !== 20'h0FFFD) begin n_err++; $display("FAIL rd_fffd_addr got %h exp 0FFFD", sa); end
    n_vec++; if (rdata !== 16'hCAFE) begin n_err++; $display("FAIL rd_fffd_data got %h exp CAFE", rdata); end
  endtask

  task automatic test_sram_write();
    int lat, oe_n, we_n, dqoe_n, ce_n;
    logic [19:0] sa;
    logic [15:0] dqo;
    do_access(1'b1, 16'h3000, 16'hBEEF, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wr_latency got %0d exp 4", lat); end
    n_vec++; if (we_n !== 2) begin n_err++; $display("FAIL wr_we_cycles got %0d exp 2", we_n); end
    n_vec++; if (dqoe_n !== 4) begin n_err++; $display("FAIL wr_dqoe_cycles got %0d exp 4", dqoe_n); end
    n_vec++; if (oe_n !== 0) begin n_err++; $display("FAIL wr_oe_cycles got %0d exp 0", oe_n); end
    n_vec++; if (ce_n !== 4) begin n_err++; $display("FAIL wr_ce_cycles got %0d exp 4", ce_n); end
    n_vec++; if (dqo !== 16'hBEEF) begin n_err++; $display("FAIL wr_dq_out got %h exp BEEF", dqo); end
    n_vec++; if (sa !== 20'h03000) begin n_err++; $display("FAIL wr_sram_addr got %h exp 03000", sa); end
    n_vec++; if (rdata !== 16'hCAFE) begin n_err++; $display("FAIL wr_rdata_kept got %h exp CAFE", rdata); end
    n_vec++; if ({SRAM_DQ_oe, Mem_WE} !== 2'b01) begin n_err++; $display("FAIL wr_after got %b exp 01", {SRAM_DQ_oe, Mem_WE}); end
  endtask

  task automatic test_io();
    int lat, oe_n, we_n, dqoe_n, ce_n;
    logic [19:0] sa;
    logic [15:0] dqo;
    do_access(1'b1, 16'hFFFF, 16'hABCD, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL io_hex_latency got %0d exp 1", lat); end
    n_vec++; if ((ce_n + we_n + oe_n + dqoe_n) !== 0) begin n_err++; $display("FAIL io_strobes got %0d active exp 0", ce_n + we_n + oe_n + dqoe_n); end
    n_vec++; if (HEX !== 16'hABCD) begin n_err++; $display("FAIL io_hex got %h exp ABCD", HEX); end
    do_access(1'b1, 16'hFFFE, 16'hFFFF, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (LED !== 12'hFFF) begin n_err++; $display("FAIL io_led got %h exp FFF", LED); end
    n_vec++; if (rdata !== 16'hCAFE) begin n_err++; $display("FAIL io_rdata_kept got %h exp CAFE", rdata); end
    n_vec++; if (HEX !== 16'hABCD) begin n_err++; $display("FAIL io_hex_kept got %h exp ABCD", HEX); end
    Switches = 16'h5A5A;
    step(); step(); step();
    do_access(1'b0, 16'hFFFF, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL io_sw_latency got %0d exp 1", lat); end
    n_vec++; if (rdata !== 16'h5A5A) begin n_err++; $display("FAIL io_sw got %h exp 5A5A", rdata); end
    do_access(1'b0, 16'hFFFE, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (rdata !== 16'h0FFF) begin n_err++; $display("FAIL io_led_read got %h exp 0FFF", rdata); end
    // A switch change takes two edges to reach the read path.
    Switches = 16'h1111;
    do_access(1'b0, 16'hFFFF, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (rdata !== 16'h5A5A) begin n_err++; $display("FAIL io_sw_sync_old got %h exp 5A5A", rdata); end
    do_access(1'b0, 16'hFFFF, 16'h0, lat, oe_n, we_n, dqoe_n, ce_n, sa, dqo);
    n_vec++; if (rdata !== 16'h1111) begin n_err++; $display("FAIL io_sw_sync_new got %h exp 1111", rdata); end
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    we = 1'b1; addr = 16'h2000; wdata = 16'h1357; req = 1'b1;
    step();
    req = 1'b0;
    step();
    n_vec++; if ({Mem_WE, SRAM_DQ_oe} !== 2'b01) begin n_err++; $display("FAIL mid_access got we/oe %b exp 01", {Mem_WE, SRAM_DQ_oe}); end
    Reset = 1'b1;
    step();
    n_vec++; if ({Mem_WE, SRAM_DQ_oe, busy, ack, Mem_CE} !== 5'b10001) begin n_err++; $display("FAIL abort_state got %b exp 10001", {Mem_WE, SRAM_DQ_oe, busy, ack, Mem_CE}); end
    n_vec++; if ({HEX, LED, rdata} !== 44'h0) begin n_err++; $display("FAIL abort_regs got %h/%h/%h exp 0", HEX, LED, rdata); end
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack || busy) acks++;
    end
    n_vec++; if (acks !== 0) begin n_err++; $display("FAIL abort_no_ack got %0d exp 0", acks); end
  endtask

  task automatic test_back_to_back();
    int a1 = -1;
    int a2 = -1;
    SRAM_DQ_in = 16'h0777;
    we = 1'b0; addr = 16'h0020; wdata = 16'h0; req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (ack) begin
        if (a1 < 0) begin
          a1 = i;
          n_vec++; if (rdata !== 16'h0777) begin n_err++; $display("FAIL b2b_rdata got %h exp 0777", rdata); end
          we = 1'b1; addr = 16'h0040; wdata = 16'h2468;
        end else begin
          a2 = i;
          break;
        end
      end
      if ((a1 > 0) && (i == a1 + 1)) begin
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy %b exp 0", busy); end
      end
      if ((a1 > 0) && (i == a1 + 2)) begin
        req = 1'b0;
        n_vec++; if ({busy, SRAM_DQ_oe, Mem_WE, Mem_CE} !== 4'b1110) begin n_err++; $display("FAIL b2b_setup got %b exp 1110", {busy, SRAM_DQ_oe, Mem_WE, Mem_CE}); end
        n_vec++; if (SRAM_ADDR !== 20'h00040) begin n_err++; $display("FAIL b2b_addr got %h exp 00040", SRAM_ADDR); end
      end
    end
    req = 1'b0;
    step();
    n_vec++; if (a1 !== 4) begin n_err++; $display("FAIL b2b_first_ack got %0d exp 4", a1); end
    n_vec++; if (a2 !== 9) begin n_err++; $display("FAIL b2b_second_ack got %0d exp 9", a2); end
    n_vec++; if (rdata !== 16'h0777) begin n_err++; $display("FAIL b2b_rdata_kept got %h exp 0777", rdata); end
  endtask

  task automatic test_wait1();
    int lat = -1;
    int oe_n = 0;
    SRAM_DQ_in = 16'h0ABC;
    we1 = 1'b0; addr1 = 16'h0055; req1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) req1 = 1'b0;
      if (!Mem_OE1) oe_n++;
      if (ack1) begin
        lat = i;
        break;
      end
    end
    step();
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL w1_latency got %0d exp 3", lat); end
    n_vec++; if (oe_n !== 2) begin n_err++; $display("FAIL w1_oe_cycles got %0d exp 2", oe_n); end
    n_vec++; if (rdata1 !== 16'h0ABC) begin n_err++; $display("FAIL w1_rdata got %h exp 0ABC", rdata1); end
  endtask

  initial begin
    Reset = 1'b1; Switches = '0; SRAM_DQ_in = '0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_reset_mid_access();
    test_back_to_back();
    test_wait1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
